// File: rtl/quiz_round_if.sv
// Host/player-facing signal bundle for quiz_round_ctrl.
// master drives start/clear/buttons; slave (the controller) drives the round outputs.
interface quiz_round_if;
  logic       start_pulse;
  logic       clear_pulse;
  logic [7:0] sw;
  logic [3:0] winner;
  logic [3:0] count;
  logic       disp_sel;
  logic       foul;
  logic       beep;
  logic [1:0] state;

  modport master (
    output start_pulse, clear_pulse, sw,
    input  winner, count, disp_sel, foul, beep, state
  );

  modport slave (
    input  start_pulse, clear_pulse, sw,
    output winner, count, disp_sel, foul, beep, state
  );
endinterface

// File: rtl/quiz_round_ctrl.sv
// Quiz round sequencer and eight-player buzzer arbiter (IDLE/ARMED/LOCKED/TIMEOUT).
// Define QUIZ_FOUL_DETECT_EN to latch early presses in IDLE as a foul.
module quiz_round_ctrl #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned ANSWER_SECS = 9,
  parameter int unsigned BEEP_MS     = 200
) (
  input  logic        clk,
  input  logic        rst,
  quiz_round_if.slave bus
);

  localparam longint unsigned BeepCycRaw = longint'(BEEP_MS) * longint'(CLK_HZ) / 64'd1000;
  localparam int unsigned     BeepCyc    = (BeepCycRaw == 0) ? 1 : 32'(BeepCycRaw);
  localparam int unsigned     PreW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned     BeepW      = (BeepCyc > 1) ? $clog2(BeepCyc) : 1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StLocked  = 2'd2,
    StTimeout = 2'd3
  } state_e;

  state_e            r_state, w_state;
  logic [7:0]        r_sw_meta, r_sw_sync;
  logic [PreW-1:0]   r_presc, w_presc;
  logic [3:0]        r_count, w_count;
  logic [3:0]        r_winner, w_winner;
  logic              r_foul, w_foul;
  logic              r_disp_sel, w_disp_sel;
  logic              r_beep, w_beep;
  logic [BeepW-1:0]  r_beep_cnt, w_beep_cnt;
  logic              w_beep_fire;
  logic              w_wrap;
  logic              w_press;

  // Lowest set bit wins so simultaneous presses favour the lower player number.
  function automatic logic [3:0] first_player(input logic [7:0] v);
    logic [3:0] res;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) res = 4'(i + 1);
    end
    return res;
  endfunction

  assign w_wrap  = (r_presc == PreW'(CLK_HZ - 1));
  assign w_press = |r_sw_sync;

  always_comb begin
    w_state     = r_state;
    w_presc     = r_presc;
    w_count     = r_count;
    w_winner    = r_winner;
    w_foul      = r_foul;
    w_beep_fire = 1'b0;

    if (bus.clear_pulse) begin
      w_state  = StIdle;
      w_presc  = '0;
      w_count  = 4'(ANSWER_SECS);
      w_winner = 4'd0;
      w_foul   = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_presc = '0;
          w_count = 4'(ANSWER_SECS);
`ifdef QUIZ_FOUL_DETECT_EN
          if (!r_foul) begin
            if (w_press) begin
              w_winner    = first_player(r_sw_sync);
              w_foul      = 1'b1;
              w_beep_fire = 1'b1;
            end else if (bus.start_pulse) begin
              w_state = StArmed;
            end
          end
`else
          w_winner = 4'd0;
          if (bus.start_pulse) w_state = StArmed;
`endif
        end
        StArmed: begin
          // A press on the final-tick cycle wins and freezes count at 1.
          if (w_press) begin
            w_state     = StLocked;
            w_winner    = first_player(r_sw_sync);
            w_beep_fire = 1'b1;
          end else if (w_wrap) begin
            w_presc = '0;
            w_count = r_count - 4'd1;
            if (r_count == 4'd1) begin
              w_state     = StTimeout;
              w_beep_fire = 1'b1;
            end
          end else begin
            w_presc = r_presc + PreW'(1);
          end
        end
        StLocked: begin
        end
        StTimeout: begin
          w_count  = 4'd0;
          w_winner = 4'd0;
        end
        default: w_state = StIdle;
      endcase
    end

    w_disp_sel = (w_state == StLocked) || w_foul;

    w_beep     = r_beep;
    w_beep_cnt = r_beep_cnt;
    if (bus.clear_pulse) begin
      w_beep     = 1'b0;
      w_beep_cnt = '0;
    end else if (w_beep_fire) begin
      w_beep     = 1'b1;
      w_beep_cnt = BeepW'(BeepCyc - 1);
    end else if (r_beep) begin
      if (r_beep_cnt == '0) w_beep = 1'b0;
      else                  w_beep_cnt = r_beep_cnt - BeepW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_meta  <= 8'd0;
      r_sw_sync  <= 8'd0;
      r_state    <= StIdle;
      r_presc    <= '0;
      r_count    <= 4'(ANSWER_SECS);
      r_winner   <= 4'd0;
      r_foul     <= 1'b0;
      r_disp_sel <= 1'b0;
      r_beep     <= 1'b0;
      r_beep_cnt <= '0;
    end else begin
      r_sw_meta  <= bus.sw;
      r_sw_sync  <= r_sw_meta;
      r_state    <= w_state;
      r_presc    <= w_presc;
      r_count    <= w_count;
      r_winner   <= w_winner;
      r_foul     <= w_foul;
      r_disp_sel <= w_disp_sel;
      r_beep     <= w_beep;
      r_beep_cnt <= w_beep_cnt;
    end
  end

  assign bus.winner   = r_winner;
  assign bus.count    = r_count;
  assign bus.disp_sel = r_disp_sel;
  assign bus.foul     = r_foul;
  assign bus.beep     = r_beep;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Scoreboard bench for quiz_round_ctrl: each expected output change (value and cycle)
// is queued by the stimulus; a monitor pops one entry per observed change.
module tb_quiz_round_ctrl;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  quiz_round_if bus();

  quiz_round_ctrl #(
    .CLK_HZ      (1000),
    .ANSWER_SECS (3),
    .BEEP_MS     (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          cyc;
    string       nm;
    logic [12:0] val;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [12:0] pk(input logic [1:0] st, input logic [3:0] w,
                                     input logic [3:0] c, input logic ds,
                                     input logic f, input logic b);
    return {st, w, c, ds, f, b};
  endfunction

  function automatic void push(input int c, input string n, input logic [12:0] v);
    exp_t e;
    e.cyc = c;
    e.nm  = n;
    e.val = v;
    exp_q.push_back(e);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: any change of the output tuple is one scoreboard event.
  initial begin
    logic [12:0] obs;
    logic [12:0] prev;
    exp_t        e;
    prev = 'x;
    forever begin
      @(negedge clk);
      obs = {bus.state, bus.winner, bus.count, bus.disp_sel, bus.foul, bus.beep};
      if (obs !== prev) begin
        prev = obs;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got=%h", cyc, obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e.val || (e.cyc >= 0 && e.cyc != cyc)) begin
            errors++;
            $display("FAIL %s got=%h@%0d exp=%h@%0d", e.nm, obs, cyc, e.val, e.cyc);
          end
        end
      end
    end
  end

  task automatic go_to(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    bus.start_pulse = 1'b1;
    @(posedge clk);
    #1;
    bus.start_pulse = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear_pulse = 1'b1;
    @(posedge clk);
    #1;
    bus.clear_pulse = 1'b0;
  endtask

  int a;
  int c;
  int t;

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.start_pulse = 1'b0;
    bus.clear_pulse = 1'b0;
    bus.sw          = 8'h00;
    push(-1, "reset", pk(2'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    go_to(cyc + 5);

    // Full countdown to timeout; starts while not idle must be ignored.
    a = cyc + 1;
    push(a,        "arm1",     pk(2'd1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0));
    push(a + 1000, "cnt2",     pk(2'd1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0));
    push(a + 2000, "cnt1",     pk(2'd1, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0));
    push(a + 3000, "timeout",  pk(2'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1));
    push(a + 3010, "to_boff",  pk(2'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    pulse_start();
    go_to(a + 1499);
    pulse_start();
    go_to(a + 3100);
    pulse_start();
    go_to(cyc + 5);
    c = cyc + 1;
    push(c, "clr_to", pk(2'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0));
    pulse_clear();

    // Player 6 mid-round; count freezes at 2.
    go_to(cyc + 5);
    a = cyc + 1;
    push(a,        "arm2",     pk(2'd1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0));
    push(a + 1000, "cnt2b",    pk(2'd1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0));
    pulse_start();
    go_to(a + 1499);
    push(a + 1502, "lock6",    pk(2'd2, 4'd6, 4'd2, 1'b1, 1'b0, 1'b1));
    push(a + 1512, "lock6_bo", pk(2'd2, 4'd6, 4'd2, 1'b1, 1'b0, 1'b0));
    bus.sw = 8'h20;
    go_to(a + 1600);
    bus.sw = 8'h00;
    go_to(a + 2100);
    c = cyc + 1;
    push(c, "clr_lk6", pk(2'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0));
    pulse_clear();

    // Simultaneous players 1 and 8, later press ignored.
    go_to(cyc + 5);
    a = cyc + 1;
    push(a, "arm3", pk(2'd1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0));
    pulse_start();
    go_to(a + 100);
    push(a + 103, "lock1",    pk(2'd2, 4'd1, 4'd3, 1'b1, 1'b0, 1'b1));
    push(a + 113, "lock1_bo", pk(2'd2, 4'd1, 4'd3, 1'b1, 1'b0, 1'b0));
    bus.sw = 8'h81;
    go_to(a + 150);
    bus.sw = 8'h00;
    go_to(a + 200);
    bus.sw = 8'h02;
    go_to(a + 250);
    bus.sw = 8'h00;
    go_to(a + 300);
    c = cyc + 1;
    push(c, "clr_lk1", pk(2'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0));
    pulse_clear();

    // Press synchronized on the final-tick cycle: press wins, count holds 1.
    go_to(cyc + 5);
    a = cyc + 1;
    push(a,        "arm4",     pk(2'd1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0));
    push(a + 1000, "cnt2c",    pk(2'd1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0));
    push(a + 2000, "cnt1c",    pk(2'd1, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0));
    push(a + 3000, "lock4",    pk(2'd2, 4'd4, 4'd1, 1'b1, 1'b0, 1'b1));
    push(a + 3010, "lock4_bo", pk(2'd2, 4'd4, 4'd1, 1'b1, 1'b0, 1'b0));
    pulse_start();
    go_to(a + 2997);
    bus.sw = 8'h08;
    go_to(a + 3050);
    bus.sw = 8'h00;
    go_to(a + 3100);
    c = cyc + 1;
    push(c, "clr_lk4", pk(2'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0));
    pulse_clear();

    // Start and clear together in IDLE: clear wins, nothing changes.
    go_to(cyc + 5);
    bus.start_pulse = 1'b1;
    bus.clear_pulse = 1'b1;
    @(posedge clk);
    #1;
    bus.start_pulse = 1'b0;
    bus.clear_pulse = 1'b0;
    go_to(cyc + 20);

    // Clear mid-countdown reloads count.
    a = cyc + 1;
    push(a,        "arm5",   pk(2'd1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0));
    push(a + 1000, "cnt2d",  pk(2'd1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0));
    pulse_start();
    go_to(a + 1499);
    push(a + 1500, "clr_arm", pk(2'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0));
    pulse_clear();

    // Clear while beeping forces beep low at once.
    go_to(cyc + 5);
    a = cyc + 1;
    push(a, "arm6", pk(2'd1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0));
    pulse_start();
    go_to(a + 49);
    push(a + 52, "lock1b", pk(2'd2, 4'd1, 4'd3, 1'b1, 1'b0, 1'b1));
    bus.sw = 8'h01;
    go_to(a + 53);
    bus.sw = 8'h00;
    go_to(a + 55);
    push(a + 56, "clr_beep", pk(2'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0));
    pulse_clear();

    // Early press in IDLE.
    go_to(cyc + 10);
    t = cyc;
`ifdef QUIZ_FOUL_DETECT_EN
    push(t + 3,  "foul5",    pk(2'd0, 4'd5, 4'd3, 1'b1, 1'b1, 1'b1));
    push(t + 13, "foul5_bo", pk(2'd0, 4'd5, 4'd3, 1'b1, 1'b1, 1'b0));
`endif
    bus.sw = 8'h10;
    go_to(t + 20);
    bus.sw = 8'h00;
    go_to(t + 30);
    bus.sw = 8'h01;
    go_to(t + 40);
    bus.sw = 8'h00;
    go_to(t + 50);
`ifdef QUIZ_FOUL_DETECT_EN
    pulse_start();
    go_to(t + 60);
    push(t + 61, "clr_foul", pk(2'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0));
`else
    go_to(t + 60);
`endif
    pulse_clear();

    go_to(cyc + 50);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got=%0d pending exp=0 first=%s", exp_q.size(),
               exp_q[0].nm);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quiz_round_ctrl.md
# quiz_round_ctrl

Round controller and buzzer arbiter for the eight-player quiz machine. It takes the host's debounced start and clear pulses and the eight raw player buttons, and sequences each round through idle, armed countdown, lock-in and timeout. It outputs the winning player number, the remaining seconds, a display-select flag and the buzzer drive. It replaces the ad-hoc glue between button handling, countdown and the display mux, and feeds the seven-segment decoder directly.

## Interface
- CLK_HZ, 50_000_000: clk frequency; one second equals CLK_HZ cycles.
- ANSWER_SECS, 9: countdown start value; range 1..15.
- BEEP_MS, 200: buzzer pulse length in ms; beep lasts BEEP_MS*CLK_HZ/1000 cycles.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start_pulse  in  1  one-cycle host start (already debounced).
- clear_pulse  in  1  one-cycle host clear (already debounced).
- sw  in  8  raw player buttons, active-high; sw[0] is player 1.
- winner  out  4  locked player 1..8; 0 when none.
- count  out  4  seconds remaining.
- disp_sel  out  1  1 = display winner, 0 = display count.
- foul  out  1  early-press indicator (macro-dependent).
- beep  out  1  buzzer drive, active-high.
- state  out  2  IDLE=0, ARMED=1, LOCKED=2, TIMEOUT=3.

## Operation
- sw passes through a 2-flop synchronizer per bit. The state machine sees only synchronized values.
- IDLE:
  - count = ANSWER_SECS, winner = 0.
  - start_pulse -> ARMED. This clears the prescaler and reloads count.
- ARMED:
  - The prescaler counts 0..CLK_HZ-1. At wrap, count decrements.
  - Any synchronized press -> LOCKED. winner = index+1 of the lowest set bit, so simultaneous presses resolve to the lower player number.
  - A prescaler wrap with count==1 -> count=0 and go to TIMEOUT.
  - If a press and the final tick land on the same cycle, the press wins: LOCKED, and count holds 1.
- LOCKED:
  - count freezes. winner is held; further presses are ignored.
  - disp_sel=1.
- TIMEOUT:
  - count=0, winner=0, disp_sel=0.
  - Presses are ignored.
- Clear and start:
  - clear_pulse returns to IDLE from any state. It has priority over start and presses on the same cycle.
  - start_pulse outside IDLE is ignored.
- beep:
  - Goes high for the beep length on every entry to LOCKED or TIMEOUT, and on foul entry.
  - A new entry restarts the beep timer.
  - clear_pulse forces beep low.
- disp_sel is 0 in IDLE, ARMED and TIMEOUT, and 1 in LOCKED.

## Timing
- Reset values: state=IDLE, winner=0, count=ANSWER_SECS, disp_sel=0, foul=0, beep=0. Prescaler, beep timer and synchronizers are all cleared.
- Press latency: a sw edge captured at edge n gives registered winner/state at edge n+3 (2 sync stages plus 1 FSM register).
- start_pulse at edge n gives state=ARMED at n+1. The first decrement happens at n+1+CLK_HZ.
- TIMEOUT is entered exactly ANSWER_SECS*CLK_HZ cycles after ARMED entry.
- Beep rises on the same edge as the state change and lasts exactly the beep length in cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: QUIZ_FOUL_DETECT_EN.
- When defined:
  - A synchronized press in IDLE records winner = that player (lowest index wins) and sets foul=1, disp_sel=1, and fires the beep.
  - The state stays IDLE. start_pulse is ignored while foul=1.
  - Only clear_pulse clears foul and winner.
- When undefined:
  - Presses in IDLE are ignored.
  - foul is tied to 0.

## Test plan
Bench uses CLK_HZ=1000, ANSWER_SECS=3, BEEP_MS=10, giving a beep of 10 cycles.
- Reset, then start -> state=1, count steps 3,2,1,0 at 1000-cycle spacing. TIMEOUT at cycle 3000 after ARMED; beep high for 10 cycles.
- Start, then sw=8'h20 at 1500 cycles -> winner=6, state=2, disp_sel=1 at edge +3. count holds 2; beep for 10 cycles.
- sw=8'h81 asserted in the same cycle while ARMED -> winner=1. A later sw=8'h02 leaves winner=1.
- sw[3] pressed so it is synchronized on the cycle of the final tick (count==1) -> LOCKED, winner=4, count=1.
- Start and clear on the same cycle in IDLE -> stays IDLE. clear mid-ARMED -> IDLE, count=3, beep=0.
- With QUIZ_FOUL_DETECT_EN, sw[4] pressed in IDLE -> foul=1, winner=5, and a following start is ignored. Clear -> foul=0, winner=0. Without the macro -> no change.
